// File: rtl/instruction_sequencer_pkg.sv
// rtl/instruction_sequencer_pkg.sv - opcodes, FSM states and instruction width derivation
package seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_READ = 4'b0011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int ins_w(input int depth);
        return (depth > 2) ? depth : 2;
    endfunction

    function automatic int ins_d(input int depth, input int w);
        return ((1 << depth) > w) ? (1 << depth) : w;
    endfunction

    // opcode(4) + mode(2) + two PE coordinates + payload
    function automatic int ins_width(input int depth, input int w);
        return 4 + 2 + 2 * ins_w(depth) + ins_d(depth, w);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - first-word-fall-through result queue with occupancy count
module result_fifo #(
    parameter int WIDTH = 44,
    parameter int FA    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic [FA:0]      count
);

    localparam logic [FA:0] DEPTH = (FA+1)'(1 << FA);

    logic [WIDTH-1:0] mem_q [2**FA];
    logic [FA-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FA-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FA:0]      count_q, count_d;
    logic             pop, full, wr_en;

    assign m_tvalid = (count_q != '0);
    assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

    always_comb begin
        pop      = m_tvalid && m_tready;
        full     = (count_q == DEPTH);
        // at full, a push is only accepted into the slot being vacated by a pop
        wr_en    = s_tvalid && (!full || pop);
        wr_ptr_d = wr_en ? wr_ptr_q + FA'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + FA'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (FA+1)'(1);
            2'b01:   count_d = count_q - (FA+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            assert (!(s_tvalid && full && !pop));
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= s_tdata;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - issues a preloaded program to the Accelerator and queues read results
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int  depth  = 3,
    parameter int  W      = 16,
    parameter int  PA     = 6,
    parameter int  FA     = 3,
    parameter int  RD_LAT = 1,
    localparam int IW     = ins_width(depth, W)
) (
    input  logic            CLK,
    input  logic            nRESET,
    input  logic            progWe,
    input  logic [PA-1:0]   progAddr,
    input  logic [IW-1:0]   progData,
    input  logic [PA:0]     progLen,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [IW-1:0]   instruction,
    input  logic [W-1:0]    dataOut,
    output logic            resValid,
    input  logic            resReady,
    output logic [IW+W-1:0] resData,
    output logic [FA:0]     resCount
);

    localparam logic [FA+1:0] FIFO_DEPTH = (FA+2)'(1 << FA);

    state_e                    state_q, state_d;
    logic [PA-1:0]             pc_q, pc_d;
    logic [PA:0]               len_q, len_d;
    logic [IW-1:0]             instr_q, instr_d;
    logic                      done_q, done_d;
    logic [RD_LAT-1:0]         tag_valid_q, tag_valid_d;
    logic [RD_LAT-1:0][IW-1:0] tag_instr_q, tag_instr_d;
    logic [IW-1:0]             prog_mem_q [2**PA];

    logic [IW-1:0] cur_word;
    logic          cur_is_read, instr_is_read, last_issue, read_ok, pop;
    logic [FA+1:0] inflight, occupancy;

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign instruction = instr_q;

    always_ff @(posedge CLK) begin
        if (progWe && !busy) begin
            prog_mem_q[progAddr] <= progData;
        end
    end

    // reads in flight = one on the instruction bus plus those waiting in the tag pipe
    always_comb begin
        cur_word      = prog_mem_q[pc_q];
        cur_is_read   = (cur_word[IW-1 -: 4] == OP_READ);
        instr_is_read = (instr_q[IW-1 -: 4] == OP_READ);
        last_issue    = ({1'b0, pc_q} == len_q - (PA+1)'(1));
        pop           = resValid && resReady;
        inflight      = (FA+2)'(instr_is_read);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + (FA+2)'(tag_valid_q[i]);
        end
        occupancy = {1'b0, resCount} + inflight - (FA+2)'(pop);
        read_ok   = (occupancy < FIFO_DEPTH);
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        len_d          = len_q;
        instr_d        = '0;
        done_d         = 1'b0;
        tag_valid_d[0] = instr_is_read;
        tag_instr_d[0] = instr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_instr_d[i] = tag_instr_q[i-1];
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (progLen != '0) begin
                        state_d = RUN;
                        pc_d    = '0;
                        len_d   = progLen;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // a blocked read leaves a NOP bubble and retries the same pc
                if (!cur_is_read || read_ok) begin
                    instr_d = cur_word;
                    pc_d    = pc_q + PA'(1);
                    if (last_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (inflight == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            instr_q     <= '0;
            done_q      <= 1'b0;
            tag_valid_q <= '0;
            tag_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            instr_q     <= instr_d;
            done_q      <= done_d;
            tag_valid_q <= tag_valid_d;
            tag_instr_q <= tag_instr_d;
        end
    end

    result_fifo #(
        .WIDTH (IW + W),
        .FA    (FA)
    ) u_result_fifo (
        .clk      (CLK),
        .rst_n    (nRESET),
        .s_tvalid (tag_valid_q[RD_LAT-1]),
        .s_tdata  ({tag_instr_q[RD_LAT-1], dataOut}),
        .m_tvalid (resValid),
        .m_tready (resReady),
        .m_tdata  (resData),
        .count    (resCount)
    );

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Hardware instruction issuer for Accelerator; replaces file-driven instruction feed.
- Host preloads an instruction program into local memory, pulses start; block issues one instruction per CLK to Accelerator.instruction.
- For every read instruction (opcode 4'b0011), captures Accelerator.dataOut and returns {instruction,dataOut} to the host through a valid/ready result FIFO.

Parameters:
- depth, 3, log2 of PE array size D; sets insW/insD as in Accelerator
- W, 16, data word width
- PA, 6, program memory address width (2^PA instructions)
- FA, 3, result FIFO address width (2^FA entries)
- RD_LAT, 1, cycles from read instruction presented to dataOut valid (>=1)
- derived: insW = max(2,depth); insD = max(2^depth,W); insWidth = 4+2+2*insW+insD (28 at defaults)

Ports:
- CLK  in  1  clock, all state on rising edge
- nRESET  in  1  asynchronous active-low reset
- progWe  in  1  program write strobe
- progAddr  in  PA  program write address
- progData  in  insWidth  program write data
- progLen  in  PA+1  number of instructions to run, sampled at start
- start  in  1  one-cycle run request
- busy  out  1  high in RUN/DRAIN
- done  out  1  one-cycle pulse at run completion
- instruction  out  insWidth  to Accelerator.instruction
- dataOut  in  W  from Accelerator.dataOut
- resValid  out  1  result FIFO non-empty
- resReady  in  1  host accepts result
- resData  out  insWidth+W  {instruction,dataOut} at FIFO head
- resCount  out  FA+1  FIFO occupancy

Behaviour:
- Reset (async, nRESET=0): state IDLE; instruction=0 (NOP); busy=0; done=0; FIFO empty, resValid=0, resCount=0, resData=0; in-flight read pipeline cleared; program memory contents not reset.
- Opcode field = instruction[insWidth-1 -: 4]; NOP = all-zero word; READ = 4'b0011.
- States:
  - IDLE: instruction=NOP. start=1 and progLen!=0 -> RUN, pc=0. start=1 and progLen==0 -> done pulse next cycle, stay IDLE.
  - RUN: each cycle, presents mem[pc] registered on instruction; pc++. Last issue (pc==len-1) -> DRAIN.
  - DRAIN: instruction=NOP; when no reads in flight -> IDLE with done=1 for one cycle.
- Read-issue throttle: a READ at mem[pc] issues only if resCount + inflight < 2^FA (counted after this cycle's pop). Otherwise NOP is issued and pc holds. Non-read instructions never stall.
- Capture: RD_LAT-deep shift register of {valid,instruction} tags. When a tag emerges, pushes {tag.instruction,dataOut} into the FIFO that cycle. The throttle guarantees no overflow. An overflow attempt is a design error and fires a simulation assertion.
- FIFO: first-word-fall-through. resData valid whenever resValid=1. Pop on resValid&resReady. Simultaneous push and pop at full or empty are both legal; count is unchanged at full, and at empty the pushed word appears next cycle.
- Program memory: progWe writes mem[progAddr]=progData when not busy. Writes while busy are ignored. start while busy is ignored.
- Issue latency: first instruction appears on instruction one cycle after start is sampled.
- Reset mid-run returns to reset state immediately. Pending results are discarded and no done pulse is generated.

Decomposition:
- Package seq_pkg:
  - insW/insD/insWidth derivation functions
  - OP_NOP=4'b0000, OP_READ=4'b0011
  - state enum IDLE/RUN/DRAIN
- Sub-module result_fifo (parameterised width/FA, FWFT, count output). The top holds program RAM, pc, FSM, throttle and capture pipeline.

Test Plan:
- Load 4 non-read words A,B,C,D, progLen=4, start -> A,B,C,D on instruction in 4 consecutive cycles after start, then NOP. done pulses once, 1 cycle after DRAIN empties (5th cycle post-start at RD_LAT=1). No FIFO writes.
- Program [NOP, READ x, NOP], stub dataOut=16'h1234 RD_LAT cycles after READ -> one FIFO entry {READ x,16'h1234}, resCount=1, done after capture.
- 10 consecutive READs, resReady=0 -> exactly 8 issued, NOPs inserted and pc frozen, resCount=8. Raise resReady -> remaining 2 issue, 10 results in order, no loss.
- progLen=0, start -> done pulse next cycle, busy never high, instruction stays NOP.
- Drop nRESET during RUN with 3 results queued -> instruction=0, resValid=0, resCount=0, busy=0 asynchronously. A new start replays the program from pc=0.
- FIFO full with resReady=1 and a capture in the same cycle -> resCount stays 8, head advances, order preserved. progWe during busy leaves memory unchanged (read back on the next run).
